// File: rtl/prog_fetch_loader_if.sv
// Instruction handshake between the fetch/loader front end and the execute
// stage. The fetch side presents instructions; execute accepts them and
// returns taken-jump information on the accept cycle.
interface prog_fetch_loader_if #(
    parameter int AW = 4
);
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    instr_data;
    logic [AW-1:0] instr_pc;
    logic          jump_en;
    logic [AW-1:0] jump_addr;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready,
        input  jump_en,
        input  jump_addr
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready,
        output jump_en,
        output jump_addr
    );
endinterface

// File: rtl/prog_fetch_loader.sv
// Program loader and instruction fetch front end of the small CPU.
// A program is clocked in byte-by-byte from raw chip pins into a small
// instruction store, then streamed in order to the execute stage over a
// valid/ready handshake, honouring taken jumps and stopping on HALT or
// at the end of the loaded program.
module prog_fetch_loader #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = $clog2(DEPTH),
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_mode,
    input  logic                load_strobe,
    input  logic [7:0]          load_data,
    prog_fetch_loader_if.master ibus,
    output logic [AW:0]         prog_len,
    output logic                overflow,
    output logic                halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Pin synchronisers; the strobe has a third flop for edge detection
    logic mode_meta_r;
    logic mode_sync_r;
    logic strobe_meta_r;
    logic strobe_sync_r;
    logic strobe_prev_r;

    logic [1:0]    state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   prog_len_r;
    logic          overflow_r;
    logic          halted_r;
    logic          instr_valid_r;
    logic [7:0]    instr_data_r;
    logic [AW-1:0] instr_pc_r;

    // Instruction store; contents are deliberately not reset
    logic [7:0] mem_r [DEPTH];

    logic          strobe_edge_s;
    logic          full_s;
    logic          wr_en_s;
    logic          accept_s;
    logic [AW:0]   seq_pc_ext_s;
    logic          jump_oob_s;
    logic          acc_halt_s;
    logic [AW-1:0] next_pc_s;

    assign strobe_edge_s = strobe_sync_r & ~strobe_prev_r;
    assign full_s        = (prog_len_r == (AW+1)'(DEPTH));
    assign wr_en_s       = ~rst & (state_r == ST_LOAD) & mode_sync_r & strobe_edge_s & ~full_s;
    assign accept_s      = instr_valid_r & ibus.instr_ready;
    assign seq_pc_ext_s  = {1'b0, pc_r} + (AW+1)'(1);
    assign jump_oob_s    = ({1'b0, ibus.jump_addr} >= prog_len_r);

    assign ibus.instr_valid = instr_valid_r;
    assign ibus.instr_data  = instr_data_r;
    assign ibus.instr_pc    = instr_pc_r;
    assign prog_len         = prog_len_r;
    assign overflow         = overflow_r;
    assign halted           = halted_r;

    // Two-flop synchronisers for load_mode and load_strobe plus strobe edge flop
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_meta_r   <= 1'b0;
            mode_sync_r   <= 1'b0;
            strobe_meta_r <= 1'b0;
            strobe_sync_r <= 1'b0;
            strobe_prev_r <= 1'b0;
        end else begin
            mode_meta_r   <= load_mode;
            mode_sync_r   <= mode_meta_r;
            strobe_meta_r <= load_strobe;
            strobe_sync_r <= strobe_meta_r;
            strobe_prev_r <= strobe_sync_r;
        end
    end

    // Write one program byte per detected strobe edge while there is room
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= load_data;
        end
    end

    // Accept decision: HALT opcode beats jump, jump beats end-of-program
    always_comb begin
        next_pc_s  = pc_r;
        acc_halt_s = 1'b0;
        if (instr_data_r == HALT_OP) begin
            acc_halt_s = 1'b1;
        end else if (ibus.jump_en) begin
            next_pc_s = ibus.jump_addr;
            if (jump_oob_s) begin
                acc_halt_s = 1'b1;
            end else begin
                acc_halt_s = 1'b0;
            end
        end else if (seq_pc_ext_s == prog_len_r) begin
            acc_halt_s = 1'b1;
        end else begin
            next_pc_s = seq_pc_ext_s[AW-1:0];
        end
    end

    // Main load/fetch state machine with registered instruction outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= '0;
            wr_ptr_r      <= '0;
            prog_len_r    <= '0;
            overflow_r    <= 1'b0;
            halted_r      <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_data_r  <= 8'h00;
            instr_pc_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mode_sync_r) begin
                        state_r    <= ST_LOAD;
                        wr_ptr_r   <= '0;
                        prog_len_r <= '0;
                        overflow_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!mode_sync_r) begin
                        if (prog_len_r != '0) begin
                            state_r  <= ST_FETCH;
                            pc_r     <= '0;
                            halted_r <= 1'b0;
                        end else begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end
                    end else if (strobe_edge_s) begin
                        if (!full_s) begin
                            wr_ptr_r   <= wr_ptr_r + AW'(1);
                            prog_len_r <= prog_len_r + (AW+1)'(1);
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (mode_sync_r) begin
                        // Abort: drop the instruction, keep only the pc effect of an accept
                        state_r       <= ST_LOAD;
                        instr_valid_r <= 1'b0;
                        wr_ptr_r      <= '0;
                        prog_len_r    <= '0;
                        overflow_r    <= 1'b0;
                        if (accept_s) begin
                            pc_r <= next_pc_s;
                        end
                    end else if (!instr_valid_r) begin
                        instr_valid_r <= 1'b1;
                        instr_data_r  <= mem_r[pc_r];
                        instr_pc_r    <= pc_r;
                    end else if (accept_s) begin
                        pc_r <= next_pc_s;
                        if (acc_halt_s) begin
                            state_r       <= ST_HALT;
                            instr_valid_r <= 1'b0;
                            halted_r      <= 1'b1;
                        end else begin
                            instr_data_r <= mem_r[next_pc_s];
                            instr_pc_r   <= next_pc_s;
                        end
                    end
                end
                ST_HALT: begin
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b1;
                    if (mode_sync_r) begin
                        state_r    <= ST_LOAD;
                        wr_ptr_r   <= '0;
                        prog_len_r <= '0;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch_loader.sv
// Directed bench for prog_fetch_loader: loads programs through the pin
// interface and checks the fetched stream against a scoreboard queue.
module tb_prog_fetch_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_mode;
    logic       load_strobe;
    logic [7:0] load_data;
    logic [4:0] prog_len;
    logic       overflow;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;
    int ld_idx  = 0;

    // Expected {pc, data} in fetch order
    logic [11:0] exp_q[$];

    prog_fetch_loader_if #(.AW(4)) ibus ();

    prog_fetch_loader #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_mode  (load_mode),
        .load_strobe(load_strobe),
        .load_data  (load_data),
        .ibus       (ibus),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enter_load();
        load_mode = 1'b1;
        repeat (4) @(negedge clk);
        ld_idx = 0;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit push);
        load_data   = d;
        load_strobe = 1'b1;
        if (push) exp_q.push_back({ld_idx[3:0], d});
        ld_idx++;
        repeat (4) @(negedge clk);
        load_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 12 && ibus.instr_valid !== 1'b1; i++) @(negedge clk);
        check("first_valid", ibus.instr_valid, 1);
    endtask

    task automatic run_fetch(input int jmp_at, input logic [3:0] jaddr);
        logic [11:0] e;
        bit done;
        done = 1'b0;
        ibus.instr_ready = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (exp_q.size() == 0) begin
                check("halt_flag", halted, 1);
                check("halt_valid", ibus.instr_valid, 0);
                ibus.jump_en = 1'b0;
                done = 1'b1;
            end else begin
                if (ibus.instr_valid === 1'b1) begin
                    e = exp_q.pop_front();
                    check("fetch_pc", ibus.instr_pc, e[11:8]);
                    check("fetch_data", ibus.instr_data, e[7:0]);
                    if (jmp_at >= 0 && ibus.instr_pc == jmp_at[3:0]) begin
                        ibus.jump_en   = 1'b1;
                        ibus.jump_addr = jaddr;
                    end else begin
                        ibus.jump_en = 1'b0;
                    end
                end else begin
                    ibus.jump_en = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) check("fetch_timeout", exp_q.size(), 0);
        ibus.instr_ready = 1'b0;
        ibus.jump_en     = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        rst              = 1'b1;
        load_mode        = 1'b0;
        load_strobe      = 1'b0;
        load_data        = 8'h00;
        ibus.instr_ready = 1'b0;
        ibus.jump_en     = 1'b0;
        ibus.jump_addr   = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", ibus.instr_valid, 0);
        check("rst_data", ibus.instr_data, 0);
        check("rst_pc", ibus.instr_pc, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);

        // Three bytes ending in HALT opcode
        enter_load();
        load_byte(8'h11, 1'b1);
        load_byte(8'h22, 1'b1);
        load_byte(8'hFF, 1'b1);
        check("t1_prog_len", prog_len, 3);
        load_mode = 1'b0;
        wait_valid();
        run_fetch(-1, 4'h0);
        check("t1_prog_len_after", prog_len, 3);

        // Seventeen strobes into a sixteen-entry store
        enter_load();
        for (int i = 0; i < 17; i++) load_byte(8'(i), i < 16);
        check("ovf_prog_len", prog_len, 16);
        check("ovf_flag", overflow, 1);
        load_mode = 1'b0;
        wait_valid();
        run_fetch(-1, 4'h0);

        // Stall with ready low, then drain to end-of-program halt
        enter_load();
        check("reload_overflow_clr", overflow, 0);
        check("reload_prog_len_clr", prog_len, 0);
        load_byte(8'h01, 1'b1);
        load_byte(8'h02, 1'b1);
        load_byte(8'h03, 1'b1);
        load_byte(8'h04, 1'b1);
        load_mode = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", ibus.instr_valid, 1);
            check("stall_data", ibus.instr_data, 8'h01);
            check("stall_pc", ibus.instr_pc, 0);
        end
        run_fetch(-1, 4'h0);

        // In-range jump from pc 1 to pc 6
        enter_load();
        for (int i = 0; i < 8; i++) load_byte(8'h30 + 8'(i), 1'b0);
        exp_q.push_back({4'd0, 8'h30});
        exp_q.push_back({4'd1, 8'h31});
        exp_q.push_back({4'd6, 8'h36});
        exp_q.push_back({4'd7, 8'h37});
        load_mode = 1'b0;
        wait_valid();
        run_fetch(1, 4'd6);

        // Out-of-range jump halts
        enter_load();
        for (int i = 0; i < 8; i++) load_byte(8'h30 + 8'(i), 1'b0);
        exp_q.push_back({4'd0, 8'h30});
        exp_q.push_back({4'd1, 8'h31});
        load_mode = 1'b0;
        wait_valid();
        run_fetch(1, 4'd12);

        // Reset in the middle of a load
        enter_load();
        load_byte(8'h5A, 1'b0);
        load_byte(8'hA5, 1'b0);
        check("pre_rst_prog_len", prog_len, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", ibus.instr_valid, 0);
        check("midrst_data", ibus.instr_data, 0);
        check("midrst_pc", ibus.instr_pc, 0);
        check("midrst_prog_len", prog_len, 0);
        check("midrst_halted", halted, 0);
        rst       = 1'b0;
        load_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Empty program goes straight to halt
        enter_load();
        load_mode = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ibus.instr_valid !== 1'b0) seen = 1'b1;
        end
        check("empty_no_valid", seen, 0);
        check("empty_halted", halted, 1);

        // Abort a run by raising load_mode during fetch
        enter_load();
        for (int i = 0; i < 4; i++) load_byte(8'h40 + 8'(i), 1'b0);
        load_mode = 1'b0;
        wait_valid();
        load_mode = 1'b1;
        for (int i = 0; i < 3 && ibus.instr_valid === 1'b1; i++) @(negedge clk);
        check("abort_valid_drop", ibus.instr_valid, 0);
        repeat (2) @(negedge clk);
        check("abort_prog_len", prog_len, 0);
        check("abort_overflow", overflow, 0);

        load_mode = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
